uart_rx_framed: RTL and testbench
=================================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised oversampling UART receiver with configurable word length, parity and stop bits.
//  Samples each bit three times and takes a majority vote; rejects false start bits.
//  Reports parity, framing and overrun errors alongside each received word.
//  Keeps the rdy/rdy_clr handshake of the existing receiver.
//  Sits between the pad-side rx line and the host-side byte consumer (FIFO or CPU register).
// PARAMETERS
//  DATA_BITS   8   word length; legal range 5..9
//  OVERSAMPLE  16  sample_en ticks per bit; even; >= 8
//  PARITY      0   0 = none, 1 = even, 2 = odd
//  STOP_BITS   1   1 or 2
// PORTS
//  clk         in   1          system clock; all logic on the rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  sample_en   in   1          oversample tick at OVERSAMPLE x baud; tie to 1 to sample every clk
//  rx          in   1          asynchronous serial line; idle high
//  rdy_clr     in   1          consumer acknowledge; clears rdy and overrun
//  dout        out  DATA_BITS  last received word, LSB = first bit on the line
//  rdy         out  1          word available in dout
//  parity_err  out  1          parity mismatch on the word in dout; always 0 when PARITY = 0
//  frame_err   out  1          a stop bit of the word in dout was sampled low
//  overrun     out  1          a word was delivered while rdy was still set; sticky
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  Reset
//   - While rst_n = 0: all outputs 0, state IDLE, counters 0.
//   - The two synchroniser flops reset to 1. A partial frame is discarded.
//  Input synchroniser and counting
//   - rx passes through 2 flops to give rx_s (2 clk latency).
//   - Every counter and state change advances only on clk cycles with sample_en = 1.
//   - rdy_clr is acted on every clk, regardless of sample_en.
//  Bit counter and vote
//   - cnt runs 0..OVERSAMPLE-1.
//   - Vote V = majority of rx_s at the three sample points cnt = T-2, T-1 and T.
//   - The bit decision is taken at cnt = T.
//  States
//   - IDLE: rx_s = 0 while armed -> START, cnt <= 0.
//     - armed is set by any rx_s = 1 sample; it is cleared by a frame_err.
//     - This handles a break condition: no re-trigger until the line returns high.
//   - START: T = OVERSAMPLE/2-1.
//     - V = 1 -> IDLE (glitch rejected, no outputs change).
//     - V = 0 -> DATA, cnt <= 0, bit index <= 0. This aligns later decisions to mid-bit.
//   - DATA: T = OVERSAMPLE-1. Store V at the current bit index, LSB first.
//     - After DATA_BITS bits: -> PARITY if PARITY != 0, else -> STOP.
//   - PARITY: T = OVERSAMPLE-1.
//     - Parity error = (XOR of data bits ^ V) != (PARITY == 2).
//     - Then -> STOP.
//   - STOP: T = OVERSAMPLE-1, repeated STOP_BITS times. Any V = 0 sets the frame error.
//     - At the last stop decision (the delivery cycle):
//       - dout <= word
//       - parity_err, frame_err <= this frame's flags
//       - rdy <= 1
//       - overrun <= overrun | (rdy & ~rdy_clr)
//       - -> IDLE
//     - Exit is at mid stop bit, so a start edge arriving half a bit later is still caught.
//  Error delivery
//   - Words with errors are still delivered. The flags are qualifiers and do not suppress rdy.
//   - parity_err and frame_err hold until the next delivery.
//  Handshake
//   - rdy_clr = 1 -> rdy <= 0 and overrun <= 0 on the next clk edge.
//   - rdy_clr = 1 in the delivery cycle: delivery wins, so rdy = 1 and no overrun.
//  Latency
//   - rdy rises 3 clk after the sample_en edge that carries the last stop sample to rx_s.
//   - Nominally (DATA_BITS + P + STOP_BITS + 0.5) bit times after the start edge, where P = 1 if parity is on.
// TESTING  (OVERSAMPLE = 16, sample_en = 1, 8N1 unless stated)
//  1. Send 0xA5 at 16 clk/bit -> rdy = 1, dout = 0xA5, errors = 0.
//     Pulse rdy_clr -> rdy = 0 next clk.
//     Repeat with sample_en = 1 in every 4 clk and 64 clk/bit -> same result.
//  2. Idle line with a 4-sample low glitch -> rdy stays 0; busy is high for no more than 8 samples.
//  3. PARITY = 1: send 0x03 with parity bit 1 -> dout = 0x03, parity_err = 1.
//     Send 0x03 with parity bit 0 -> parity_err = 0.
//  4. Hold rx low for 20 bit times, then high -> exactly one delivery: dout = 0x00, frame_err = 1.
//     A following 0x3C frame is received cleanly.
//  5. Send 0x11 then 0x22 back to back with no rdy_clr -> dout = 0x22, overrun = 1.
//     rdy_clr -> overrun = 0, rdy = 0.
//  6. Assert rst_n = 0 during data bit 4 -> all outputs 0 while asserted and no rdy afterwards.
//     Next frame 0x5A -> dout = 0x5A, no errors.
//     Also check DATA_BITS = 9, STOP_BITS = 2, PARITY = 2 with word 0x1FF.

Source files
------------

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote, parity/frame/overrun flags.
// Latency: word delivered at the mid-point of the last stop bit (about 3 clk after it reaches the pin).
// Backpressure: none; a word delivered while rdy is still set raises sticky overrun.
module uart_rx_framed #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] T_START  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_BIT    = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_m, rx_s;
    logic [1:0]           hist;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bidx_q;
    logic                 stop_q;
    logic                 armed_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic vote;
    logic at_t;
    logic last_stop;
    logic deliver;
    logic ferr_next;

    // hist holds the two previous ticks' samples, so the vote covers cnt = T-2, T-1, T
    assign vote      = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    assign at_t      = sample_en && (state_q != S_IDLE) &&
                       (cnt_q == ((state_q == S_START) ? T_START : T_BIT));
    assign last_stop = (STOP_BITS == 1) || stop_q;
    assign ferr_next = ferr_q | ~vote;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        deliver = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_en && !rx_s && armed_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_t) begin
                    state_d = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (at_t && (bidx_q == LAST_BIT)) begin
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (at_t) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_t && last_stop) begin
                    state_d = S_IDLE;
                    deliver = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            hist       <= 2'b11;
            cnt_q      <= '0;
            bidx_q     <= '0;
            stop_q     <= 1'b0;
            armed_q    <= 1'b0;
            word_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dout       <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;

            if (sample_en) begin
                hist <= {hist[0], rx_s};
                if ((state_q == S_IDLE) || at_t) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (rx_s) begin
                    armed_q <= 1'b1;
                end
            end

            if (at_t) begin
                case (state_q)
                    S_START: begin
                        bidx_q <= '0;
                        stop_q <= 1'b0;
                        perr_q <= 1'b0;
                        ferr_q <= 1'b0;
                    end
                    S_DATA: begin
                        word_q <= {vote, word_q[DATA_BITS-1:1]};
                        bidx_q <= bidx_q + BW'(1);
                    end
                    S_PARITY: perr_q <= ((^word_q) ^ vote) != (PARITY == 2);
                    S_STOP: begin
                        ferr_q <= ferr_next;
                        stop_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // A delivery outranks a same-cycle rdy_clr; a framing error disarms until the line idles high
            if (deliver) begin
                dout       <= word_q;
                parity_err <= perr_q;
                frame_err  <= ferr_next;
                rdy        <= 1'b1;
                overrun    <= overrun | (rdy & ~rdy_clr);
                if (ferr_next) begin
                    armed_q <= 1'b0;
                end
            end else if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed and randomised frames into three receiver configurations (8N1, 8E1, 9O2),
// compared against a frame-level reference model of word, flags and the rdy/overrun handshake.
module tb_uart_rx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sample_en;
    logic line;
    logic clr;
    int   sel = 0;
    int   div = 1;
    int   ph  = 0;

    int checks = 0;
    int errors = 0;

    bit model_rdy[3];
    bit model_ovr[3];

    logic rx_a, rx_b, rx_c, clr_a, clr_b, clr_c;
    assign rx_a  = (sel == 0) ? line : 1'b1;
    assign rx_b  = (sel == 1) ? line : 1'b1;
    assign rx_c  = (sel == 2) ? line : 1'b1;
    assign clr_a = (sel == 0) & clr;
    assign clr_b = (sel == 1) & clr;
    assign clr_c = (sel == 2) & clr;

    logic [7:0] dout_a, dout_b;
    logic [8:0] dout_c;
    logic rdy_a, perr_a, ferr_a, ovr_a, busy_a;
    logic rdy_b, perr_b, ferr_b, ovr_b, busy_b;
    logic rdy_c, perr_c, ferr_c, ovr_c, busy_c;

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rx(rx_a), .rdy_clr(clr_a),
        .dout(dout_a), .rdy(rdy_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rx(rx_b), .rdy_clr(clr_b),
        .dout(dout_b), .rdy(rdy_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    uart_rx_framed #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rx(rx_c), .rdy_clr(clr_c),
        .dout(dout_c), .rdy(rdy_c), .parity_err(perr_c), .frame_err(ferr_c),
        .overrun(ovr_c), .busy(busy_c)
    );

    logic [8:0] o_dout;
    logic o_rdy, o_perr, o_ferr, o_ovr, o_busy;
    always_comb begin
        o_dout = {1'b0, dout_a};
        o_rdy  = rdy_a;
        o_perr = perr_a;
        o_ferr = ferr_a;
        o_ovr  = ovr_a;
        o_busy = busy_a;
        if (sel == 1) begin
            o_dout = {1'b0, dout_b};
            o_rdy  = rdy_b;
            o_perr = perr_b;
            o_ferr = ferr_b;
            o_ovr  = ovr_b;
            o_busy = busy_b;
        end else if (sel == 2) begin
            o_dout = dout_c;
            o_rdy  = rdy_c;
            o_perr = perr_c;
            o_ferr = ferr_c;
            o_ovr  = ovr_c;
            o_busy = busy_c;
        end
    end

    // rising edges of rdy on the 8N1 receiver, used to count deliveries
    logic rdy_a_d = 1'b0;
    int   rise_a  = 0;
    always @(posedge clk) begin
        rdy_a_d <= rdy_a;
        if (rdy_a && !rdy_a_d) rise_a <= rise_a + 1;
    end

    initial begin
        sample_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (div <= 1) begin
                sample_en = 1'b1;
            end else begin
                ph = (ph + 1) % div;
                sample_en = (ph == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int pbit, input int nstop, input logic [1:0] stopv,
                              input int cpb);
        sel  = which;
        line = 1'b0;
        tick(cpb);
        for (int i = 0; i < nbits; i++) begin
            line = data[i];
            tick(cpb);
        end
        if (pbit >= 0) begin
            line = pbit[0];
            tick(cpb);
        end
        for (int i = 0; i < nstop; i++) begin
            line = stopv[i];
            tick(cpb);
        end
        line = 1'b1;
    endtask

    // Reference: word is the data bits; parity error when the received data+parity
    // bits have the wrong overall sense; frame error when any stop bit was low.
    task automatic expect_frame(input string tag, input int which, input logic [8:0] data,
                                input int nbits, input int mode, input int pbit,
                                input int nstop, input logic [1:0] stopv);
        logic [8:0] mask;
        logic [8:0] word;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovr;
        int         n;
        sel  = which;
        mask = (nbits == 9) ? 9'h1FF : 9'h0FF;
        word = data & mask;
        exp_perr = 1'b0;
        if (mode != 0) exp_perr = ((^word) ^ pbit[0]) != (mode == 2);
        exp_ferr = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stopv[i]) exp_ferr = 1'b1;
        exp_ovr = model_ovr[which] | model_rdy[which];
        n = 0;
        while (o_rdy !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check({tag, "_rdy"}, {8'd0, o_rdy}, 9'd1);
        check({tag, "_dout"}, o_dout, word);
        check({tag, "_perr"}, {8'd0, o_perr}, {8'd0, exp_perr});
        check({tag, "_ferr"}, {8'd0, o_ferr}, {8'd0, exp_ferr});
        check({tag, "_ovr"}, {8'd0, o_ovr}, {8'd0, exp_ovr});
        model_rdy[which] = 1'b1;
        model_ovr[which] = exp_ovr;
    endtask

    task automatic clear_rdy(input string tag);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        model_rdy[sel] = 1'b0;
        model_ovr[sel] = 1'b0;
        check({tag, "_rdy"}, {8'd0, o_rdy}, 9'd0);
        check({tag, "_ovr"}, {8'd0, o_ovr}, 9'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, o_dout, 9'd0);
        check({tag, "_rdy"}, {8'd0, o_rdy}, 9'd0);
        check({tag, "_perr"}, {8'd0, o_perr}, 9'd0);
        check({tag, "_ferr"}, {8'd0, o_ferr}, 9'd0);
        check({tag, "_ovr"}, {8'd0, o_ovr}, 9'd0);
        check({tag, "_busy"}, {8'd0, o_busy}, 9'd0);
    endtask

    initial begin
        int         busy_cnt;
        int         rise0;
        logic [8:0] d;
        int         pb;
        logic [1:0] sv;

        rst_n = 1'b0;
        line  = 1'b1;
        clr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_rdy[i] = 1'b0;
            model_ovr[i] = 1'b0;
        end
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(8);

        // basic reception at two oversample rates
        send_frame(0, 9'h0A5, 8, -1, 1, 2'b11, 16);
        expect_frame("t1_a5", 0, 9'h0A5, 8, 0, 0, 1, 2'b11);
        clear_rdy("t1_clr");
        tick(16);
        div = 4;
        tick(8);
        send_frame(0, 9'h0A5, 8, -1, 1, 2'b11, 64);
        expect_frame("t1_a5_slow", 0, 9'h0A5, 8, 0, 0, 1, 2'b11);
        clear_rdy("t1_slow_clr");
        div = 1;
        tick(16);

        // short low glitch on an idle line
        sel = 0;
        line = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 44; i++) begin
            tick(1);
            if (o_busy) busy_cnt++;
            if (i == 3) line = 1'b1;
        end
        checks++;
        assert (busy_cnt >= 1 && busy_cnt <= 8) else begin
            errors++;
            $error("FAIL t2_busy_len: observed %0d expected 1..8", busy_cnt);
        end
        check("t2_no_rdy", {8'd0, o_rdy}, 9'd0);

        // break: line low for 20 bit times
        rise0 = rise_a;
        line = 1'b0;
        tick(320);
        line = 1'b1;
        tick(48);
        check("t4_one_delivery", 9'(rise_a - rise0), 9'd1);
        expect_frame("t4_break", 0, 9'h000, 8, 0, 0, 1, 2'b00);
        clear_rdy("t4_clr");
        tick(16);
        send_frame(0, 9'h03C, 8, -1, 1, 2'b11, 16);
        expect_frame("t4_3c", 0, 9'h03C, 8, 0, 0, 1, 2'b11);
        clear_rdy("t4_3c_clr");
        tick(16);

        // back-to-back frames without acknowledge
        send_frame(0, 9'h011, 8, -1, 1, 2'b11, 16);
        expect_frame("t5_11", 0, 9'h011, 8, 0, 0, 1, 2'b11);
        send_frame(0, 9'h022, 8, -1, 1, 2'b11, 16);
        expect_frame("t5_22", 0, 9'h022, 8, 0, 0, 1, 2'b11);
        clear_rdy("t5_clr");
        tick(16);

        // reset in the middle of data bit 4, with a pending word in dout
        send_frame(0, 9'h03C, 8, -1, 1, 2'b11, 16);
        expect_frame("t6_pre", 0, 9'h03C, 8, 0, 0, 1, 2'b11);
        tick(16);
        fork
            send_frame(0, 9'h096, 8, -1, 1, 2'b11, 16);
            begin
                tick(16 + 4 * 16 + 8);
                rst_n = 1'b0;
                tick(1);
                check_all_zero("t6_in_reset");
            end
        join
        tick(10);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_rdy[i] = 1'b0;
            model_ovr[i] = 1'b0;
        end
        tick(64);
        check("t6_no_rdy", {8'd0, o_rdy}, 9'd0);
        send_frame(0, 9'h05A, 8, -1, 1, 2'b11, 16);
        expect_frame("t6_5a", 0, 9'h05A, 8, 0, 0, 1, 2'b11);
        clear_rdy("t6_clr");
        tick(16);

        // random 8N1 frames, occasional bad stop bit, acknowledge at random
        for (int k = 0; k < 8; k++) begin
            d  = 9'($urandom_range(0, 255));
            sv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
            send_frame(0, d, 8, -1, 1, sv, 16);
            expect_frame("rnd_a", 0, d, 8, 0, 0, 1, sv);
            if ($urandom_range(0, 1) != 0) clear_rdy("rnd_a_clr");
            tick(32);
        end
        clear_rdy("rnd_a_end");

        // even parity receiver
        send_frame(1, 9'h003, 8, 1, 1, 2'b11, 16);
        expect_frame("t3_p1", 1, 9'h003, 8, 1, 1, 1, 2'b11);
        clear_rdy("t3_p1_clr");
        tick(16);
        send_frame(1, 9'h003, 8, 0, 1, 2'b11, 16);
        expect_frame("t3_p0", 1, 9'h003, 8, 1, 0, 1, 2'b11);
        clear_rdy("t3_p0_clr");
        tick(16);
        for (int k = 0; k < 6; k++) begin
            d  = 9'($urandom_range(0, 255));
            pb = int'($urandom_range(0, 1));
            send_frame(1, d, 8, pb, 1, 2'b11, 16);
            expect_frame("rnd_b", 1, d, 8, 1, pb, 1, 2'b11);
            clear_rdy("rnd_b_clr");
            tick(24);
        end

        // 9 data bits, odd parity, two stop bits
        send_frame(2, 9'h1FF, 9, 0, 2, 2'b11, 16);
        expect_frame("t6_1ff", 2, 9'h1FF, 9, 2, 0, 2, 2'b11);
        clear_rdy("t6_1ff_clr");
        tick(16);
        for (int k = 0; k < 5; k++) begin
            d  = 9'($urandom_range(0, 511));
            pb = int'($urandom_range(0, 1));
            sv = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
            send_frame(2, d, 9, pb, 2, sv, 16);
            expect_frame("rnd_c", 2, d, 9, 2, pb, 2, sv);
            clear_rdy("rnd_c_clr");
            tick(32);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
